// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_pkg                                                    |
// | Description : Shared definitions for the cpu_mem_stall core: opcode      |
// |               values, ALU function select encoding and FSM states.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package cpu_pkg;

   // Opcode field INSTRUCTION[31:24]
   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_LWD   = 8'h08;
   localparam logic [7:0] OP_LWI   = 8'h09;
   localparam logic [7:0] OP_SWD   = 8'h0A;
   localparam logic [7:0] OP_SWI   = 8'h0B;
   localparam logic [7:0] OP_BNE   = 8'h0C;
   localparam logic [7:0] OP_MULT  = 8'h0D;
   localparam logic [7:0] OP_SLL   = 8'h0E;
   localparam logic [7:0] OP_SRL   = 8'h0F;
   localparam logic [7:0] OP_SRA   = 8'h10;
   localparam logic [7:0] OP_ROR   = 8'h11;

   localparam int ALU_SEL_W = 4;

   typedef enum logic [ALU_SEL_W-1:0] {
      ALU_FWD = 4'd0,
      ALU_ADD = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_MUL = 4'd4,
      ALU_SLL = 4'd5,
      ALU_SRL = 4'd6,
      ALU_SRA = 4'd7,
      ALU_ROR = 4'd8
   } alu_sel_t;

   typedef enum logic [0:0] {
      ST_EXEC = 1'b0,
      ST_MEM  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_alu_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_alu_p                                                  |
// | Description : Combinational ALU. Forward, add, and, or, multiply (low    |
// |               half), logical shifts, arithmetic right shift and rotate   |
// |               right. ZERO flags an all-zero result.                      |
// | Ports       : i_a      first operand (shift/rotate source)               |
// |               i_b      second operand (forward source)                   |
// |               i_shamt  shift/rotate amount (unsigned, 8 bits)            |
// |               i_sel    function select (alu_sel_t encoding)              |
// |               o_result result, DATA_W bits                               |
// |               o_zero   1 when o_result == 0                              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module cpu_alu_p
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0]    i_a,
   input  logic [DATA_W-1:0]    i_b,
   input  logic [7:0]           i_shamt,
   input  logic [ALU_SEL_W-1:0] i_sel,
   output logic [DATA_W-1:0]    o_result,
   output logic                 o_zero
);

   logic       w_big;   // shift amount reaches or exceeds the word width
   logic [7:0] w_rot;   // rotate amount reduced modulo DATA_W

   assign w_big = ({24'd0, i_shamt} >= 32'(DATA_W));
   assign w_rot = 8'({24'd0, i_shamt} % 32'(DATA_W));

   always_comb begin
      o_result = '0;
      case (i_sel)
         ALU_FWD: o_result = i_b;
         ALU_ADD: o_result = i_a + i_b;
         ALU_AND: o_result = i_a & i_b;
         ALU_OR:  o_result = i_a | i_b;
         ALU_MUL: o_result = i_a * i_b;
         ALU_SLL: o_result = w_big ? '0 : (i_a << i_shamt);
         ALU_SRL: o_result = w_big ? '0 : (i_a >> i_shamt);
         ALU_SRA: o_result = w_big ? {DATA_W{i_a[DATA_W-1]}}
                                   : $unsigned($signed(i_a) >>> i_shamt);
         // A zero rotate shifts left by DATA_W, which yields 0 and leaves i_a intact.
         ALU_ROR: o_result = (i_a >> w_rot) | (i_a << (DATA_W - int'(w_rot)));
         default: o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/cpu_mem_stall.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_mem_stall                                              |
// | Description : Single-issue CPU core with load/store over a BUSYWAIT      |
// |               handshake. Non-memory ops retire in one cycle; memory ops  |
// |               issue a registered request and wait in MEM until BUSYWAIT  |
// |               drops, holding PC and the register file meanwhile.         |
// | Ports       : CLK, RESET (sync, active high)                             |
// |               PC            current instruction address                  |
// |               INSTRUCTION   {op, rd/offset, rt, rs/imm}                  |
// |               MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA  registered   |
// |               MEM_READDATA  load data, BUSYWAIT memory busy              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module cpu_mem_stall
   import cpu_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3,
   parameter int PC_W       = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   output logic [PC_W-1:0]   PC,
   input  logic [31:0]       INSTRUCTION,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [DATA_W-1:0] MEM_ADDRESS,
   output logic [DATA_W-1:0] MEM_WRITEDATA,
   input  logic [DATA_W-1:0] MEM_READDATA,
   input  logic              BUSYWAIT
);

   localparam int c_NUM_REGS = 2 ** REG_ADDR_W;

   // ---------------- state ----------------
   state_t              r_state;
   state_t              w_state_next;
   logic [PC_W-1:0]     r_pc;
   logic                r_mem_read;
   logic                r_mem_write;
   logic [DATA_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_regs [c_NUM_REGS];

   // ---------------- decode ----------------
   logic [7:0]            w_opcode;
   logic [REG_ADDR_W-1:0] w_rd_idx;
   logic [REG_ADDR_W-1:0] w_rt_idx;
   logic [REG_ADDR_W-1:0] w_rs_idx;
   logic [DATA_W-1:0]     w_rt_val;
   logic [DATA_W-1:0]     w_rs_val;
   logic [DATA_W-1:0]     w_imm;
   logic [PC_W-1:0]       w_off_ext;
   logic [PC_W-1:0]       w_pc_plus4;
   logic [PC_W-1:0]       w_pc_branch;
   logic                  w_unused_rt_hi;

   assign w_opcode    = INSTRUCTION[31:24];
   assign w_rd_idx    = INSTRUCTION[16 +: REG_ADDR_W];
   assign w_rt_idx    = INSTRUCTION[8 +: REG_ADDR_W];
   assign w_rs_idx    = INSTRUCTION[0 +: REG_ADDR_W];
   assign w_rt_val    = r_regs[w_rt_idx];
   assign w_rs_val    = r_regs[w_rs_idx];
   assign w_imm       = DATA_W'(INSTRUCTION[7:0]);
   assign w_off_ext   = {{(PC_W-8){INSTRUCTION[23]}}, INSTRUCTION[23:16]};
   assign w_pc_plus4  = r_pc + PC_W'(4);
   assign w_pc_branch = w_pc_plus4 + (w_off_ext << 2);
   // Upper rt-field bits are only meaningful for wider register files.
   assign w_unused_rt_hi = ^INSTRUCTION[15:8];

   alu_sel_t          w_alu_sel;
   logic [DATA_W-1:0] w_alu_b;
   logic [DATA_W-1:0] w_alu_result;
   logic              w_alu_zero;
   logic              w_reg_we;
   logic              w_jump;
   logic              w_beq;
   logic              w_bne;
   logic              w_load;
   logic              w_store;
   logic              w_addr_imm;
   logic              w_take;
   logic [DATA_W-1:0] w_mem_addr;

   always_comb begin
      w_alu_sel  = ALU_FWD;
      w_alu_b    = w_rs_val;
      w_reg_we   = 1'b0;
      w_jump     = 1'b0;
      w_beq      = 1'b0;
      w_bne      = 1'b0;
      w_load     = 1'b0;
      w_store    = 1'b0;
      w_addr_imm = 1'b0;
      case (w_opcode)
         OP_LOADI: begin w_alu_b = w_imm; w_reg_we = 1'b1; end
         OP_MOV:   w_reg_we = 1'b1;
         OP_ADD:   begin w_alu_sel = ALU_ADD; w_reg_we = 1'b1; end
         // Subtraction and compares share the adder via two's complement of rs.
         OP_SUB:   begin w_alu_sel = ALU_ADD; w_alu_b = ~w_rs_val + DATA_W'(1); w_reg_we = 1'b1; end
         OP_AND:   begin w_alu_sel = ALU_AND; w_reg_we = 1'b1; end
         OP_OR:    begin w_alu_sel = ALU_OR;  w_reg_we = 1'b1; end
         OP_J:     w_jump = 1'b1;
         OP_BEQ:   begin w_alu_sel = ALU_ADD; w_alu_b = ~w_rs_val + DATA_W'(1); w_beq = 1'b1; end
         OP_BNE:   begin w_alu_sel = ALU_ADD; w_alu_b = ~w_rs_val + DATA_W'(1); w_bne = 1'b1; end
         OP_LWD:   w_load = 1'b1;
         OP_LWI:   begin w_load = 1'b1; w_addr_imm = 1'b1; end
         OP_SWD:   w_store = 1'b1;
         OP_SWI:   begin w_store = 1'b1; w_addr_imm = 1'b1; end
         OP_MULT:  begin w_alu_sel = ALU_MUL; w_reg_we = 1'b1; end
         OP_SLL:   begin w_alu_sel = ALU_SLL; w_reg_we = 1'b1; end
         OP_SRL:   begin w_alu_sel = ALU_SRL; w_reg_we = 1'b1; end
         OP_SRA:   begin w_alu_sel = ALU_SRA; w_reg_we = 1'b1; end
         OP_ROR:   begin w_alu_sel = ALU_ROR; w_reg_we = 1'b1; end
         default:  ;
      endcase
   end

   cpu_alu_p #(.DATA_W(DATA_W)) u_alu (
      .i_a      (w_rt_val),
      .i_b      (w_alu_b),
      .i_shamt  (INSTRUCTION[7:0]),
      .i_sel    (w_alu_sel),
      .o_result (w_alu_result),
      .o_zero   (w_alu_zero)
   );

   assign w_take     = w_jump | (w_beq & w_alu_zero) | (w_bne & ~w_alu_zero);
   assign w_mem_addr = w_addr_imm ? w_imm : w_rs_val;

   // ---------------- next-state / commit logic ----------------
   logic [PC_W-1:0]   w_pc_next;
   logic              w_mem_read_next;
   logic              w_mem_write_next;
   logic [DATA_W-1:0] w_mem_addr_next;
   logic [DATA_W-1:0] w_mem_wdata_next;
   logic              w_rf_we;
   logic [DATA_W-1:0] w_rf_wdata;

   always_comb begin
      w_state_next     = r_state;
      w_pc_next        = r_pc;
      w_mem_read_next  = r_mem_read;
      w_mem_write_next = r_mem_write;
      w_mem_addr_next  = r_mem_addr;
      w_mem_wdata_next = r_mem_wdata;
      w_rf_we          = 1'b0;
      w_rf_wdata       = w_alu_result;
      case (r_state)
         ST_EXEC: begin
            if (w_load) begin
               w_mem_read_next = 1'b1;
               w_mem_addr_next = w_mem_addr;
               w_state_next    = ST_MEM;
            end else if (w_store) begin
               w_mem_write_next = 1'b1;
               w_mem_addr_next  = w_mem_addr;
               w_mem_wdata_next = w_rt_val;
               w_state_next     = ST_MEM;
            end else begin
               w_rf_we   = w_reg_we;
               w_pc_next = w_take ? w_pc_branch : w_pc_plus4;
            end
         end
         ST_MEM: begin
            // Everything holds while the memory is busy; rd still comes from
            // INSTRUCTION, which the fetch side keeps stable while PC is held.
            if (!BUSYWAIT) begin
               w_rf_we          = r_mem_read;
               w_rf_wdata       = MEM_READDATA;
               w_mem_read_next  = 1'b0;
               w_mem_write_next = 1'b0;
               w_pc_next        = w_pc_plus4;
               w_state_next     = ST_EXEC;
            end
         end
         default: w_state_next = ST_EXEC;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= ST_EXEC;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_pc        <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         for (int i = 0; i < c_NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_pc        <= w_pc_next;
         r_mem_read  <= w_mem_read_next;
         r_mem_write <= w_mem_write_next;
         r_mem_addr  <= w_mem_addr_next;
         r_mem_wdata <= w_mem_wdata_next;
         if (w_rf_we) r_regs[w_rd_idx] <= w_rf_wdata;
      end
   end

   assign PC            = r_pc;
   assign MEM_READ      = r_mem_read;
   assign MEM_WRITE     = r_mem_write;
   assign MEM_ADDRESS   = r_mem_addr;
   assign MEM_WRITEDATA = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_stall.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cpu_mem_stall                                           |
// | Description : Self-checking bench for cpu_mem_stall. An 8-bit and a      |
// |               16-bit core share clock, INSTRUCTION and BUSYWAIT; the one |
// |               not under test is held in reset. Register contents are     |
// |               observed through stores (MEM_WRITEDATA).                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_cpu_mem_stall;

   typedef struct {
      logic [31:0] instr;
      logic        is_store;
      logic [31:0] exp_pc;    // PC once the instruction has fully retired
      logic [15:0] exp_addr;
      logic [15:0] exp_data;
   } vec_t;

   logic        clk;
   logic        rst8, rst16, busy, sel16;
   logic [31:0] instr;
   logic [15:0] rdata;

   logic [31:0] pc8, pc16;
   logic        mr8, mw8, mr16, mw16;
   logic [7:0]  addr8, wd8;
   logic [15:0] addr16, wd16;

   logic [31:0] o_pc;
   logic        o_mr, o_mw;
   logic [15:0] o_addr, o_wd;

   int n_checks = 0;
   int n_err    = 0;

   vec_t v8  [0:33];
   vec_t v16 [0:15];

   cpu_mem_stall #(.DATA_W(8), .REG_ADDR_W(3), .PC_W(32)) dut8 (
      .CLK(clk), .RESET(rst8), .PC(pc8), .INSTRUCTION(instr),
      .MEM_READ(mr8), .MEM_WRITE(mw8), .MEM_ADDRESS(addr8),
      .MEM_WRITEDATA(wd8), .MEM_READDATA(rdata[7:0]), .BUSYWAIT(busy)
   );

   cpu_mem_stall #(.DATA_W(16), .REG_ADDR_W(3), .PC_W(32)) dut16 (
      .CLK(clk), .RESET(rst16), .PC(pc16), .INSTRUCTION(instr),
      .MEM_READ(mr16), .MEM_WRITE(mw16), .MEM_ADDRESS(addr16),
      .MEM_WRITEDATA(wd16), .MEM_READDATA(rdata), .BUSYWAIT(busy)
   );

   assign o_pc   = sel16 ? pc16   : pc8;
   assign o_mr   = sel16 ? mr16   : mr8;
   assign o_mw   = sel16 ? mw16   : mw8;
   assign o_addr = sel16 ? addr16 : {8'h00, addr8};
   assign o_wd   = sel16 ? wd16   : {8'h00, wd8};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mkn(input logic [31:0] i, input logic [31:0] pc);
      mkn = '{i, 1'b0, pc, 16'h0, 16'h0};
   endfunction

   function automatic vec_t mks(input logic [31:0] i, input logic [31:0] pc,
                                input logic [15:0] a, input logic [15:0] d);
      mks = '{i, 1'b1, pc, a, d};
   endfunction

   // Store: one EXEC cycle raising MEM_WRITE, then one zero-wait MEM cycle.
   task automatic do_store(input string tag, input logic [31:0] i, input logic [31:0] pc_before,
                           input logic [15:0] a, input logic [15:0] d);
      instr = i;
      @(posedge clk); #1;
      check({tag, " pc_hold"}, o_pc, pc_before);
      check({tag, " rw_req"}, {30'd0, o_mr, o_mw}, 32'd1);
      check({tag, " addr"}, {16'd0, o_addr}, {16'd0, a});
      check({tag, " wdata"}, {16'd0, o_wd}, {16'd0, d});
      @(posedge clk); #1;
      check({tag, " rw_done"}, {30'd0, o_mr, o_mw}, 32'd0);
      check({tag, " pc_next"}, o_pc, pc_before + 32'd4);
   endtask

   task automatic apply_vec(input string tag, input vec_t v);
      if (v.is_store) begin
         do_store(tag, v.instr, v.exp_pc - 32'd4, v.exp_addr, v.exp_data);
      end else begin
         instr = v.instr;
         @(posedge clk); #1;
         check({tag, " pc"}, o_pc, v.exp_pc);
         check({tag, " no_req"}, {30'd0, o_mr, o_mw}, 32'd0);
      end
   endtask

   initial begin
      // 8-bit program: ALU ops, shifts, stores, branches
      v8[0]  = mkn(32'h00010005, 32'h04);              // loadi r1,5
      v8[1]  = mkn(32'h00020003, 32'h08);              // loadi r2,3
      v8[2]  = mkn(32'h03030102, 32'h0C);              // sub r3=r1-r2=2
      v8[3]  = mks(32'h0B000320, 32'h10, 16'h20, 16'h02);
      v8[4]  = mkn(32'h02040102, 32'h14);              // add r4=8
      v8[5]  = mks(32'h0A000402, 32'h18, 16'h03, 16'h08); // swd r4 -> [r2]
      v8[6]  = mkn(32'h04050102, 32'h1C);              // and r5=1
      v8[7]  = mkn(32'h05060102, 32'h20);              // or r6=7
      v8[8]  = mks(32'h0B000530, 32'h24, 16'h30, 16'h01);
      v8[9]  = mks(32'h0B000631, 32'h28, 16'h31, 16'h07);
      v8[10] = mkn(32'h0D070102, 32'h2C);              // mult r7=15
      v8[11] = mks(32'h0B000732, 32'h30, 16'h32, 16'h0F);
      v8[12] = mkn(32'h0E070104, 32'h34);              // sll r7=5<<4
      v8[13] = mks(32'h0B000733, 32'h38, 16'h33, 16'h50);
      v8[14] = mkn(32'h0E070108, 32'h3C);              // sll by 8 -> 0
      v8[15] = mks(32'h0B000734, 32'h40, 16'h34, 16'h00);
      v8[16] = mkn(32'h01070002, 32'h44);              // mov r7=r2=3
      v8[17] = mkn(32'hFF070102, 32'h48);              // undefined op: NOP
      v8[18] = mks(32'h0B000735, 32'h4C, 16'h35, 16'h03);
      v8[19] = mkn(32'h0F070102, 32'h50);              // srl r7=5>>2=1
      v8[20] = mks(32'h0B000736, 32'h54, 16'h36, 16'h01);
      v8[21] = mkn(32'h00050081, 32'h58);              // loadi r5,0x81
      v8[22] = mkn(32'h10070501, 32'h5C);              // sra 1 -> C0
      v8[23] = mks(32'h0B000737, 32'h60, 16'h37, 16'hC0);
      v8[24] = mkn(32'h10070509, 32'h64);              // sra 9 -> FF
      v8[25] = mks(32'h0B000738, 32'h68, 16'h38, 16'hFF);
      v8[26] = mkn(32'h11070509, 32'h6C);              // ror 9 (=1) -> C0
      v8[27] = mks(32'h0B000739, 32'h70, 16'h39, 16'hC0);
      v8[28] = mkn(32'h00020005, 32'h74);              // loadi r2,5
      v8[29] = mkn(32'h07FE0102, 32'h70);              // beq taken: PC+4-8
      v8[30] = mkn(32'h0CFE0102, 32'h74);              // bne not taken
      v8[31] = mkn(32'h06010000, 32'h7C);              // j +1 word: PC+8
      v8[32] = mkn(32'h07FE0103, 32'h80);              // beq r1!=r3: not taken
      v8[33] = mkn(32'h0C020103, 32'h8C);              // bne taken: PC+4+8

      // 16-bit program: wide shifts, rotate, mult wrap, sub wrap
      v16[0]  = mkn(32'h00010001, 32'h04);             // loadi r1,1
      v16[1]  = mkn(32'h0E01010F, 32'h08);             // sll r1 -> 8000
      v16[2]  = mkn(32'h10020114, 32'h0C);             // sra by 20 -> FFFF
      v16[3]  = mks(32'h0B000240, 32'h10, 16'h0040, 16'hFFFF);
      v16[4]  = mks(32'h0B000141, 32'h14, 16'h0041, 16'h8000);
      v16[5]  = mkn(32'h00030001, 32'h18);             // loadi r3,1
      v16[6]  = mkn(32'h11040311, 32'h1C);             // ror by 17 -> 8000
      v16[7]  = mks(32'h0B000442, 32'h20, 16'h0042, 16'h8000);
      v16[8]  = mkn(32'h00050001, 32'h24);             // loadi r5,1
      v16[9]  = mkn(32'h0E050508, 32'h28);             // sll -> 0100
      v16[10] = mkn(32'h0D060505, 32'h2C);             // mult -> 0000
      v16[11] = mks(32'h0B000643, 32'h30, 16'h0043, 16'h0000);
      v16[12] = mkn(32'h03070003, 32'h34);             // sub r7=0-1 -> FFFF
      v16[13] = mks(32'h0B000744, 32'h38, 16'h0044, 16'hFFFF);
      v16[14] = mkn(32'h0F070710, 32'h3C);             // srl by 16 -> 0
      v16[15] = mks(32'h0B000745, 32'h40, 16'h0045, 16'h0000);

      rst8 = 1'b1; rst16 = 1'b1; busy = 1'b0; sel16 = 1'b0;
      instr = 32'h0; rdata = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset pc", o_pc, 32'h0);
      check("reset req", {30'd0, o_mr, o_mw}, 32'd0);
      check("reset addr", {16'd0, o_addr}, 32'h0);
      check("reset wdata", {16'd0, o_wd}, 32'h0);
      rst8 = 1'b0;

      for (int i = 0; i < 34; i++) apply_vec($sformatf("v8[%0d]", i), v8[i]);

      // swi r1 -> 0x10 with three busy cycles
      instr = 32'h0B000110;
      @(posedge clk); #1;
      check("stall issue", {30'd0, o_mr, o_mw}, 32'd1);
      busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("stall%0d write", k), {31'd0, o_mw}, 32'd1);
         check($sformatf("stall%0d addr", k), {16'd0, o_addr}, 32'h10);
         check($sformatf("stall%0d data", k), {16'd0, o_wd}, 32'h05);
         check($sformatf("stall%0d pc", k), o_pc, 32'h8C);
      end
      busy = 1'b0;
      @(posedge clk); #1;
      check("stall release write", {31'd0, o_mw}, 32'd0);
      check("stall release pc", o_pc, 32'h90);

      // lwi r4,0x10 from a zero-wait memory returning A5
      instr = 32'h09040010; rdata = 16'h00A5;
      @(posedge clk); #1;
      check("load req", {30'd0, o_mr, o_mw}, 32'd2);
      check("load addr", {16'd0, o_addr}, 32'h10);
      check("load pc_hold", o_pc, 32'h90);
      @(posedge clk); #1;
      check("load pulse end", {31'd0, o_mr}, 32'd0);
      check("load pc", o_pc, 32'h94);
      do_store("load result", 32'h0B000444, 32'h94, 16'h44, 16'hA5);

      // lwd r6,[r3] stalled, then reset while in MEM
      instr = 32'h08060003; rdata = 16'h005A; busy = 1'b1;
      @(posedge clk); #1;
      check("abort req", {30'd0, o_mr, o_mw}, 32'd2);
      check("abort addr", {16'd0, o_addr}, 32'h02);
      @(posedge clk); #1;
      check("abort stall", {31'd0, o_mr}, 32'd1);
      rst8 = 1'b1;
      @(posedge clk); #1;
      check("abort pc", o_pc, 32'h0);
      check("abort read", {31'd0, o_mr}, 32'd0);
      check("abort addr clr", {16'd0, o_addr}, 32'h0);
      rst8 = 1'b0; busy = 1'b0;
      do_store("abort r6", 32'h0B000650, 32'h0, 16'h50, 16'h00);

      // 16-bit core
      sel16 = 1'b1; rst8 = 1'b1;
      @(posedge clk); #1;
      rst16 = 1'b0;
      check("w16 reset pc", o_pc, 32'h0);
      for (int i = 0; i < 16; i++) apply_vec($sformatf("v16[%0d]", i), v16[i]);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
